// File: rtl/ahb_picomem_slave_bridge.sv
// AHB-Lite slave that replays bus transfers as PicoRV32 native memory requests.
// Handles lane swapping, HSIZE strobes, wait states and two-cycle ERROR responses.
module ahb_picomem_slave_bridge #(
    parameter bit BIG_ENDIAN_AHB = 1'b1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        hsel,
    input  logic [31:0] haddr,
    input  logic [1:0]  htrans,
    input  logic        hwrite,
    input  logic [2:0]  hsize,
    input  logic [3:0]  hprot,
    input  logic        hready,
    input  logic [31:0] hwdata,
    output logic        hreadyout,
    output logic        hresp,
    output logic [31:0] hrdata,
    output logic        mem_valid,
    output logic        mem_instr,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [2:0] {
        IDLE,
        WCAP,
        ACCESS,
        ERR1,
        ERR2
    } state_t;

    state_t      state;
    logic        accept;
    logic        legal;
    logic [3:0]  strb;
    logic [31:0] wdata_lane;
    logic [31:0] rdata_lane;
    logic        unused_ok;

    function automatic logic [31:0] swap32(input logic [31:0] d);
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
    endfunction

    assign unused_ok = ^hprot[3:1];

    assign accept = (state == IDLE || state == ERR2)
                  && hsel && hready && htrans[1];

    assign wdata_lane = BIG_ENDIAN_AHB ? swap32(hwdata) : hwdata;
    assign rdata_lane = BIG_ENDIAN_AHB ? swap32(mem_rdata) : mem_rdata;

    always_comb begin
        legal = 1'b0;
        strb  = 4'b0000;
        case (hsize)
            3'd0: begin
                legal = 1'b1;
                strb  = 4'b0001 << haddr[1:0];
            end
            3'd1: begin
                legal = ~haddr[0];
                strb  = haddr[1] ? 4'b1100 : 4'b0011;
            end
            3'd2: begin
                legal = (haddr[1:0] == 2'b00);
                strb  = 4'b1111;
            end
            default: begin
                legal = 1'b0;
                strb  = 4'b0000;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            hreadyout <= 1'b1;
            hresp     <= 1'b0;
            hrdata    <= '0;
            mem_valid <= 1'b0;
            mem_instr <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
        end else begin
            case (state)
                IDLE, ERR2: begin
                    state     <= IDLE;
                    hreadyout <= 1'b1;
                    hresp     <= 1'b0;
                    if (accept) begin
                        hreadyout <= 1'b0;
                        if (!legal) begin
                            state <= ERR1;
                            hresp <= 1'b1;
                        end else begin
                            mem_addr  <= {haddr[31:2], 2'b00};
                            mem_instr <= ~hprot[0];
                            if (hwrite) begin
                                mem_wstrb <= strb;
                                state     <= WCAP;
                            end else begin
                                mem_wstrb <= 4'b0000;
                                mem_valid <= 1'b1;
                                state     <= ACCESS;
                            end
                        end
                    end
                end
                // hwdata is only valid in the data phase, one cycle after acceptance
                WCAP: begin
                    mem_wdata <= wdata_lane;
                    mem_valid <= 1'b1;
                    state     <= ACCESS;
                end
                ACCESS: begin
                    if (mem_ready) begin
                        mem_valid <= 1'b0;
                        hreadyout <= 1'b1;
                        state     <= IDLE;
                        if (mem_wstrb == 4'b0000) begin
                            hrdata <= rdata_lane;
                        end
                    end
                end
                ERR1: begin
                    hreadyout <= 1'b1;
                    hresp     <= 1'b1;
                    state     <= ERR2;
                end
                default: begin
                    hreadyout <= 1'b1;
                    hresp     <= 1'b0;
                    mem_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_picomem_slave_bridge.sv
// Bench for ahb_picomem_slave_bridge: AHB driver plus a native-side responder
// that checks each request against a queue of expected requests.
module tb_ahb_picomem_slave_bridge;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        hsel = 1'b0;
    logic [31:0] haddr = '0;
    logic [1:0]  htrans = 2'b00;
    logic        hwrite = 1'b0;
    logic [2:0]  hsize = 3'd0;
    logic [3:0]  hprot = 4'b0001;
    logic        hready;
    logic [31:0] hwdata = '0;
    logic        hreadyout;
    logic        hresp;
    logic [31:0] hrdata;
    logic        mem_valid;
    logic        mem_instr;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata = 32'hDEADBEEF;

    logic        le_hreadyout;
    logic        le_hresp;
    logic [31:0] le_hrdata;
    logic        le_mem_valid;
    logic        le_mem_instr;
    logic [31:0] le_mem_addr;
    logic [31:0] le_mem_wdata;
    logic [3:0]  le_mem_wstrb;

    assign hready = hreadyout;

    always #5 clk = ~clk;

    ahb_picomem_slave_bridge #(.BIG_ENDIAN_AHB(1'b1)) u_dut (
        .clk(clk), .resetn(resetn), .hsel(hsel), .haddr(haddr),
        .htrans(htrans), .hwrite(hwrite), .hsize(hsize), .hprot(hprot),
        .hready(hready), .hwdata(hwdata), .hreadyout(hreadyout),
        .hresp(hresp), .hrdata(hrdata), .mem_valid(mem_valid),
        .mem_instr(mem_instr), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata)
    );

    ahb_picomem_slave_bridge #(.BIG_ENDIAN_AHB(1'b0)) u_le (
        .clk(clk), .resetn(resetn), .hsel(hsel), .haddr(haddr),
        .htrans(htrans), .hwrite(hwrite), .hsize(hsize), .hprot(hprot),
        .hready(hready), .hwdata(hwdata), .hreadyout(le_hreadyout),
        .hresp(le_hresp), .hrdata(le_hrdata), .mem_valid(le_mem_valid),
        .mem_instr(le_mem_instr), .mem_ready(mem_ready),
        .mem_addr(le_mem_addr), .mem_wdata(le_mem_wdata),
        .mem_wstrb(le_mem_wstrb), .mem_rdata(mem_rdata)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        logic        instr;
        logic [31:0] rdata;
        logic        le_chk;
        logic [31:0] le_wdata;
    } nat_t;

    nat_t        nat_q[$];
    logic [31:0] rd_q[$];
    int          n_chk = 0;
    int          n_fail = 0;
    int          mem_delay = 0;
    int          acc_cnt = 0;
    bit          active = 1'b0;
    nat_t        cur = '0;
    logic [68:0] snap = '0;

    task automatic chk(input string tag, input logic [95:0] got,
                       input logic [95:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] strb_mask(input logic [3:0] s);
        return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    endfunction

    task automatic exp_req(input logic [31:0] a, input logic [3:0] s,
                           input logic [31:0] wd, input logic ins,
                           input logic [31:0] rd, input logic le,
                           input logic [31:0] lwd);
        nat_t e;
        e.addr = a; e.wstrb = s; e.wdata = wd; e.instr = ins;
        e.rdata = rd; e.le_chk = le; e.le_wdata = lwd;
        nat_q.push_back(e);
    endtask

    // Native-side responder: checks each new request, then holds it for mem_delay cycles
    always @(negedge clk) begin
        if (!resetn) begin
            active    = 1'b0;
            mem_ready = 1'b0;
            mem_rdata = 32'hDEADBEEF;
        end else if (mem_valid) begin
            if (!active) begin
                active  = 1'b1;
                acc_cnt = 0;
                chk("nat_req_expected", 96'(nat_q.size() != 0), 96'd1);
                if (nat_q.size() != 0) begin
                    cur = nat_q.pop_front();
                    chk("mem_addr", mem_addr, cur.addr);
                    chk("mem_wstrb", mem_wstrb, cur.wstrb);
                    chk("mem_instr", mem_instr, cur.instr);
                    if (cur.wstrb != 4'b0000)
                        chk("mem_wdata", mem_wdata & strb_mask(cur.wstrb),
                            cur.wdata & strb_mask(cur.wstrb));
                    if (cur.le_chk) begin
                        chk("le_mem_wstrb", le_mem_wstrb, cur.wstrb);
                        chk("le_mem_wdata",
                            le_mem_wdata & strb_mask(cur.wstrb),
                            cur.le_wdata & strb_mask(cur.wstrb));
                    end
                end
                snap = {mem_addr, mem_wstrb, mem_wdata, mem_instr};
            end else begin
                acc_cnt++;
                chk("req_stable",
                    {mem_addr, mem_wstrb, mem_wdata, mem_instr}, snap);
            end
            mem_ready = (acc_cnt >= mem_delay);
            mem_rdata = mem_ready ? cur.rdata : 32'hDEADBEEF;
        end else begin
            active    = 1'b0;
            mem_ready = 1'b0;
            mem_rdata = 32'hDEADBEEF;
        end
    end

    task automatic drive_addr(input logic w, input logic [31:0] a,
                              input logic [2:0] sz, input logic [3:0] prot);
        hsel = 1'b1; htrans = 2'b10; hwrite = w;
        haddr = a; hsize = sz; hprot = prot;
    endtask

    task automatic bus_idle();
        hsel = 1'b0; htrans = 2'b00;
    endtask

    task automatic wait_done(output int waits);
        waits = 0;
        @(negedge clk);
        while (!hreadyout && waits < 64) begin
            waits++;
            @(negedge clk);
        end
        if (waits >= 64) chk("hreadyout_timeout", 96'd1, 96'd0);
    endtask

    task automatic xfer(input logic w, input logic [31:0] a,
                        input logic [2:0] sz, input logic [3:0] prot,
                        input logic [31:0] wd, input int exp_waits);
        int waits;
        @(posedge clk); #1;
        drive_addr(w, a, sz, prot);
        @(posedge clk); #1;
        bus_idle();
        hwdata = wd;
        wait_done(waits);
        chk("wait_states", waits, exp_waits);
        chk("hresp_okay", hresp, 1'b0);
        if (!w && rd_q.size() != 0) chk("hrdata", hrdata, rd_q.pop_front());
    endtask

    task automatic xfer_err(input logic w, input logic [31:0] a,
                            input logic [2:0] sz);
        @(posedge clk); #1;
        drive_addr(w, a, sz, 4'b0001);
        @(posedge clk); #1;
        bus_idle();
        @(negedge clk);
        chk("err1_hreadyout", hreadyout, 1'b0);
        chk("err1_hresp", hresp, 1'b1);
        @(negedge clk);
        chk("err2_hreadyout", hreadyout, 1'b1);
        chk("err2_hresp", hresp, 1'b1);
        @(negedge clk);
        chk("err_after_hresp", hresp, 1'b0);
        chk("err_no_valid", mem_valid, 1'b0);
    endtask

    task automatic xfer_ignored(input logic sel, input logic [1:0] tr);
        @(posedge clk); #1;
        hsel = sel; htrans = tr; hwrite = 1'b0; haddr = 32'h80; hsize = 3'd2;
        @(posedge clk); #1;
        bus_idle();
        @(negedge clk);
        chk("ign_hreadyout", hreadyout, 1'b1);
        chk("ign_hresp", hresp, 1'b0);
        @(negedge clk);
        chk("ign_no_valid", mem_valid, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int waits;
        #12;
        chk("rst_hreadyout", hreadyout, 1'b1);
        chk("rst_hresp", hresp, 1'b0);
        chk("rst_hrdata", hrdata, 32'h0);
        chk("rst_mem_valid", mem_valid, 1'b0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wstrb", mem_wstrb, 4'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_mem_instr", mem_instr, 1'b0);
        #11 resetn = 1'b1;

        mem_delay = 0;
        exp_req(32'h100, 4'b0000, 32'h0, 1'b0, 32'h44332211, 1'b0, 32'h0);
        rd_q.push_back(32'h11223344);
        xfer(1'b0, 32'h100, 3'd2, 4'b0001, 32'h0, 1);

        exp_req(32'h200, 4'b1000, 32'hAB000000, 1'b0, 32'h0, 1'b0, 32'h0);
        xfer(1'b1, 32'h203, 3'd0, 4'b0001, 32'h000000AB, 2);

        exp_req(32'h0, 4'b1100, 32'hFECA0000, 1'b0, 32'h0, 1'b1, 32'hBEEF0000);
        xfer(1'b1, 32'h002, 3'd1, 4'b0001, 32'hBEEFCAFE, 2);

        mem_delay = 1;
        exp_req(32'h2C, 4'b0000, 32'h0, 1'b1, 32'hCAFEF00D, 1'b0, 32'h0);
        rd_q.push_back(32'h0DF0FECA);
        xfer(1'b0, 32'h2C, 3'd2, 4'b0000, 32'h0, 2);

        mem_delay = 0;
        exp_req(32'h100, 4'b0000, 32'h0, 1'b0, 32'h11223344, 1'b0, 32'h0);
        rd_q.push_back(32'h44332211);
        xfer(1'b0, 32'h102, 3'd1, 4'b0001, 32'h0, 1);

        xfer_err(1'b0, 32'h101, 3'd2);
        xfer_err(1'b0, 32'h000, 3'd3);
        xfer_err(1'b1, 32'h001, 3'd1);
        chk("hrdata_held", hrdata, 32'h44332211);

        xfer_ignored(1'b0, 2'b10);
        xfer_ignored(1'b1, 2'b01);

        // Back-to-back: read address phase rides on the write's data phase
        mem_delay = 2;
        exp_req(32'h10, 4'b1111, 32'h04030201, 1'b0, 32'h0, 1'b0, 32'h0);
        exp_req(32'h14, 4'b0000, 32'h0, 1'b0, 32'h55667788, 1'b0, 32'h0);
        rd_q.push_back(32'h88776655);
        @(posedge clk); #1;
        drive_addr(1'b1, 32'h10, 3'd2, 4'b0001);
        @(posedge clk); #1;
        hwdata = 32'h01020304;
        drive_addr(1'b0, 32'h14, 3'd2, 4'b0001);
        wait_done(waits);
        chk("b2b_write_waits", waits, 4);
        @(posedge clk); #1;
        bus_idle();
        wait_done(waits);
        chk("b2b_read_waits", waits, 3);
        chk("b2b_hrdata", hrdata, rd_q.pop_front());

        mem_delay = 20;
        exp_req(32'h40, 4'b0000, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        @(posedge clk); #1;
        drive_addr(1'b0, 32'h40, 3'd2, 4'b0001);
        @(posedge clk); #1;
        bus_idle();
        @(posedge clk);
        @(posedge clk); #3;
        chk("pre_rst_valid", mem_valid, 1'b1);
        resetn = 1'b0;
        #1;
        chk("rst_acc_valid", mem_valid, 1'b0);
        chk("rst_acc_hresp", hresp, 1'b0);
        chk("rst_acc_hreadyout", hreadyout, 1'b1);
        chk("rst_acc_hrdata", hrdata, 32'h0);
        @(posedge clk); #3;
        resetn = 1'b1;

        mem_delay = 0;
        exp_req(32'h0, 4'b0000, 32'h0, 1'b0, 32'hA1B2C3D4, 1'b0, 32'h0);
        rd_q.push_back(32'hD4C3B2A1);
        xfer(1'b0, 32'h0, 3'd2, 4'b0001, 32'h0, 1);

        repeat (2) @(posedge clk);
        chk("nat_q_drained", nat_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
